// File: rtl/alu_wb_queue_arbiter.sv
// Writeback scheduler: picks one eligible ALU writeback queue per cycle, registers the grant and
// pulses that queue's serviced strobe the following cycle. Define ALU_WB_ARB_FIXED_PRIO_EN for fixed priority.
module alu_wb_queue_arbiter #(
    parameter int NUM_QUEUES = 4,
    parameter int QID_BITS   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_QUEUES-1:0] in_queue_empty,
    input  logic [NUM_QUEUES-1:0] in_head_vgpr_wr_en,
    input  logic [NUM_QUEUES-1:0] in_head_sgpr_wr_en,
    input  logic                  in_vgpr_port_busy,
    input  logic                  in_sgpr_port_busy,
    input  logic                  in_stall,
    output logic [NUM_QUEUES-1:0] out_queue_serviced,
    output logic [QID_BITS-1:0]   out_sel_qid,
    output logic                  out_sel_valid,
    output logic                  out_vgpr_wr_strobe,
    output logic                  out_sgpr_wr_strobe,
    output logic                  out_all_empty
);

    logic                  issue_valid;
    logic [QID_BITS-1:0]   issue_qid;
    logic [NUM_QUEUES-1:0] eligible;
    logic                  any_eligible;
    logic                  found_hi;
    logic [QID_BITS-1:0]   win_hi;
    logic [QID_BITS-1:0]   win_lo;
    logic [QID_BITS-1:0]   winner;

`ifndef ALU_WB_ARB_FIXED_PRIO_EN
    logic [QID_BITS-1:0]   rr_ptr;
`endif

    // The queue popping this cycle still shows a stale empty flag, so it sits out one decision.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_QUEUES; i++) begin
            eligible[i] = ~in_queue_empty[i]
                        & ~(issue_valid & (issue_qid == QID_BITS'(i)))
                        & ~(in_head_vgpr_wr_en[i] & in_vgpr_port_busy)
                        & ~(in_head_sgpr_wr_en[i] & in_sgpr_port_busy);
        end
    end

    // Descending scan so the lowest qualifying index is the one left standing.
    always_comb begin
        any_eligible = 1'b0;
        found_hi     = 1'b0;
        win_hi       = '0;
        win_lo       = '0;
        for (int i = NUM_QUEUES - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                any_eligible = 1'b1;
                win_lo       = QID_BITS'(i);
`ifndef ALU_WB_ARB_FIXED_PRIO_EN
                if (QID_BITS'(i) >= rr_ptr) begin
                    found_hi = 1'b1;
                    win_hi   = QID_BITS'(i);
                end
`endif
            end
        end
`ifdef ALU_WB_ARB_FIXED_PRIO_EN
        winner = win_lo;
`else
        // No eligible queue at or above rr_ptr means the search wraps to the lowest one.
        winner = found_hi ? win_hi : win_lo;
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            issue_valid <= 1'b0;
            issue_qid   <= '0;
        end else if (!in_stall && any_eligible) begin
            issue_valid <= 1'b1;
            issue_qid   <= winner;
        end else begin
            issue_valid <= 1'b0;
        end
    end

`ifndef ALU_WB_ARB_FIXED_PRIO_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr <= '0;
        end else if (!in_stall && any_eligible) begin
            rr_ptr <= (winner == QID_BITS'(NUM_QUEUES - 1)) ? '0 : winner + 1'b1;
        end
    end
`endif

    always_comb begin
        out_queue_serviced = '0;
        for (int i = 0; i < NUM_QUEUES; i++) begin
            out_queue_serviced[i] = issue_valid & (issue_qid == QID_BITS'(i));
        end
    end

    assign out_sel_valid      = issue_valid;
    assign out_sel_qid        = issue_qid;
    assign out_vgpr_wr_strobe = |(out_queue_serviced & in_head_vgpr_wr_en);
    assign out_sgpr_wr_strobe = |(out_queue_serviced & in_head_sgpr_wr_en);
    assign out_all_empty      = (&in_queue_empty) & ~issue_valid;

endmodule

// File: tb/tb_alu_wb_queue_arbiter.sv
// Bench for alu_wb_queue_arbiter: directed queue loads, expected pops (cycle, qid, strobes)
// queued by the driver and matched by a negedge monitor that also models the FIFO heads.
module tb_alu_wb_queue_arbiter;
  localparam int NQ = 4;
  localparam int QB = 2;
  localparam int W  = 20;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [NQ-1:0] vgpr_en = '0;
  logic [NQ-1:0] sgpr_en = '0;
  logic          vgpr_busy = 1'b0;
  logic          sgpr_busy = 1'b0;
  logic          stall = 1'b0;
  logic [NQ-1:0] q_empty;
  logic [NQ-1:0] serviced;
  logic [QB-1:0] sel_qid;
  logic          sel_valid;
  logic          vgpr_stb;
  logic          sgpr_stb;
  logic          all_empty;

  int            cnt[NQ];
  int            cyc = 0;
  int            total = 0;
  int            bad = 0;
  logic [W-1:0]  exp_q[$];

  alu_wb_queue_arbiter #(.NUM_QUEUES(NQ), .QID_BITS(QB)) dut (
    .clk                (clk),
    .rst                (rst),
    .in_queue_empty     (q_empty),
    .in_head_vgpr_wr_en (vgpr_en),
    .in_head_sgpr_wr_en (sgpr_en),
    .in_vgpr_port_busy  (vgpr_busy),
    .in_sgpr_port_busy  (sgpr_busy),
    .in_stall           (stall),
    .out_queue_serviced (serviced),
    .out_sel_qid        (sel_qid),
    .out_sel_valid      (sel_valid),
    .out_vgpr_wr_strobe (vgpr_stb),
    .out_sgpr_wr_strobe (sgpr_stb),
    .out_all_empty      (all_empty)
  );

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    for (int i = 0; i < NQ; i++) q_empty[i] = (cnt[i] == 0);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h (cyc %0d)", name, act, req, cyc);
    end
  endtask

  // driver tasks
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic expect_pop(input int c, input int q, input logic v, input logic s);
    logic [15:0]   c16;
    logic [QB-1:0] qq;
    c16 = 16'(c);
    qq  = QB'(q);
    exp_q.push_back({c16, qq, v, s});
  endtask

  task automatic do_reset();
    step();
    rst = 1'b0;
    for (int i = 0; i < NQ; i++) cnt[i] = 0;
    vgpr_en = '0; sgpr_en = '0;
    vgpr_busy = 1'b0; sgpr_busy = 1'b0; stall = 1'b0;
    #1;
    chk("rst_all_empty", 32'(all_empty), 32'd1);
    chk("rst_serviced", 32'(serviced), 32'd0);
    chk("rst_sel_valid", 32'(sel_valid), 32'd0);
    chk("rst_strobes", 32'({vgpr_stb, sgpr_stb}), 32'd0);
    cnt[0] = 1;
    #1;
    chk("rst_all_empty_follows", 32'(all_empty), 32'd0);
    cnt[0] = 0;
    step();
    rst = 1'b1;
  endtask

  task automatic drain();
    repeat (20) step();
    chk("drain_exp_q", 32'(exp_q.size()), 32'd0);
    chk("end_all_empty", 32'(all_empty), 32'd1);
    exp_q.delete();
  endtask

  // scoreboard monitor: also pops the modelled FIFO head when a pulse is seen
  always @(negedge clk) begin
    logic [W-1:0]  act;
    logic [W-1:0]  e;
    logic [15:0]   c16;
    logic [NQ-1:0] one;
    if (rst) begin
      if (sel_valid) begin
        c16 = cyc[15:0];
        act = {c16, sel_qid, vgpr_stb, sgpr_stb};
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL pop_unexpected: actual=%h required=none", act);
        end else begin
          e = exp_q.pop_front();
          chk("pop", 32'(act), 32'(e));
        end
        one = NQ'(1) << sel_qid;
        chk("serviced_onehot", 32'(serviced), 32'(one));
        if (cnt[sel_qid] > 0) cnt[sel_qid] = cnt[sel_qid] - 1;
      end else begin
        chk("serviced_idle", 32'(serviced), 32'd0);
      end
    end
  end

  initial begin
    int t;
    for (int i = 0; i < NQ; i++) cnt[i] = 0;

`ifdef ALU_WB_ARB_FIXED_PRIO_EN
    // fixed priority: q0 wins whenever eligible, q3 fills the masked cycles
    do_reset();
    step(); t = cyc;
    cnt[0] = 3; cnt[3] = 3;
    for (int k = 1; k <= 6; k++) expect_pop(t + k, (k % 2 == 1) ? 0 : 3, 1'b0, 1'b0);
    drain();
`else
    // single queue, done-only entry; rr_ptr then points at q3
    do_reset();
    step(); t = cyc;
    cnt[2] = 1;
    expect_pop(t + 1, 2, 1'b0, 1'b0);
    step(); step(); step(); t = cyc;
    cnt[0] = 1; cnt[3] = 1;
    expect_pop(t + 1, 3, 1'b0, 1'b0);
    expect_pop(t + 2, 0, 1'b0, 1'b0);
    drain();

    // all four queues with three entries: back-to-back round robin
    do_reset();
    vgpr_en = 4'b0101; sgpr_en = 4'b0011;
    step(); t = cyc;
    for (int i = 0; i < NQ; i++) cnt[i] = 3;
    #1;
    chk("busy_all_empty", 32'(all_empty), 32'd0);
    for (int k = 1; k <= 12; k++)
      expect_pop(t + k, (k - 1) % 4, vgpr_en[(k - 1) % 4], sgpr_en[(k - 1) % 4]);
    drain();

    // lone queue issues every other cycle
    do_reset();
    step(); t = cyc;
    cnt[1] = 3;
    expect_pop(t + 1, 1, 1'b0, 1'b0);
    expect_pop(t + 3, 1, 1'b0, 1'b0);
    expect_pop(t + 5, 1, 1'b0, 1'b0);
    drain();

    // vgpr port busy holds q0 back; q1 (sgpr) goes first
    do_reset();
    vgpr_en = 4'b0001; sgpr_en = 4'b0010; vgpr_busy = 1'b1;
    step(); t = cyc;
    cnt[0] = 1; cnt[1] = 1;
    expect_pop(t + 1, 1, 1'b0, 1'b1);
    expect_pop(t + 4, 0, 1'b1, 1'b0);
    step(); step(); step();
    vgpr_busy = 1'b0;
    drain();

    // stall for four cycles: the registered pop completes, then RR resumes at q2
    do_reset();
    step(); t = cyc;
    for (int i = 0; i < NQ; i++) cnt[i] = 3;
    expect_pop(t + 1, 0, 1'b0, 1'b0);
    expect_pop(t + 2, 1, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) expect_pop(t + 7 + k, (2 + k) % 4, 1'b0, 1'b0);
    step(); step();
    stall = 1'b1;
    repeat (4) step();
    stall = 1'b0;
    drain();

    // reset in the middle of a pulse clears it at once
    do_reset();
    step(); t = cyc;
    cnt[1] = 1;
    expect_pop(t + 1, 1, 1'b0, 1'b0);
    step();
    rst = 1'b0;
    #1;
    chk("midrst_serviced", 32'(serviced), 32'd0);
    chk("midrst_sel_valid", 32'(sel_valid), 32'd0);
    step();
    rst = 1'b1;
    drain();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
